// File: rtl/uart_rx_frontend_pkg.sv
// Shared UART definitions: default parameters,
// receiver FSM encoding and small helpers.
package uart_rx_frontend_pkg;

  localparam int DBIT_DEF     = 8;
  localparam int SB_TICK_DEF  = 16;
  localparam int DVSR_DEF     = 326;
  localparam int DVSR_BIT_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(
    input logic [2:0] v
  );
    return (v[0] & v[1]) |
           (v[0] & v[2]) |
           (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator,
// one-cycle tick every DVSR clocks.
module baud_tick_gen
  import uart_rx_frontend_pkg::*;
#(
  parameter int DVSR     = DVSR_DEF,
  parameter int DVSR_BIT = DVSR_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [DVSR_BIT-1:0] LAST =
    DVSR_BIT'(DVSR - 1);

  logic [DVSR_BIT-1:0] cnt_q;
  logic [DVSR_BIT-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver front end: synchronizer,
// 16x oversampling FSM, majority-voted data bits.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int DVSR     = DVSR_DEF,
  parameter int DVSR_BIT = DVSR_BIT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done_tick,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int NW =
    (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST =
    NW'(DBIT - 1);
  localparam logic [3:0] S_MID =
    4'(SB_TICK / 2);
  localparam logic [3:0] S_END =
    4'(SB_TICK - 1);

  logic tick;

  baud_tick_gen #(
    .DVSR     (DVSR),
    .DVSR_BIT (DVSR_BIT)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  logic rx_meta_q;
  logic rx_sync_q;
  logic [1:0] fill_q;
  logic armed_q, armed_d;

  rx_state_e state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [2:0] smp_q, smp_d;
  logic stop_q, stop_d;
  logic stop_ok;
  logic [DBIT-1:0] data_q, data_d;
  logic done_q, done_d;
  logic ferr_q, ferr_d;
  logic busy_q;

  // Starts are only armed once the real line,
  // not the synchronizer reset value, reads high.
  assign armed_d = armed_q |
    (fill_q[1] & rx_sync_q);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    smp_d   = smp_q;
    stop_d  = stop_q;
    stop_ok = stop_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_sync_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd7) begin
            s_d = '0;
            n_d = '0;
            state_d = rx_sync_q ?
              ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd7) smp_d[0] = rx_sync_q;
          if (s_q == 4'd8) smp_d[1] = rx_sync_q;
          if (s_q == 4'd9) smp_d[2] = rx_sync_q;
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {maj3(smp_q), b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          s_d = s_q + 4'd1;
          if (s_q == S_MID) begin
            stop_d  = rx_sync_q;
            stop_ok = rx_sync_q;
          end
          if (s_q == S_END) begin
            s_d     = '0;
            state_d = ST_IDLE;
            if (stop_ok) begin
              data_d = b_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      smp_q     <= '0;
      stop_q    <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      fill_q    <= {fill_q[0], 1'b1};
      armed_q   <= armed_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      smp_q     <= smp_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign o_data         = data_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_err    = ferr_q;
  assign o_busy         = busy_q;

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame.
REQ-002 Parameter SB_TICK, default 16: oversample ticks spanning the stop bit.
REQ-003 Parameter DVSR, default 326: clock cycles per oversample tick, i.e. Clock/(BaudRate*16).
REQ-004 Parameter DVSR_BIT, default 9: width of the divisor counter.
REQ-005 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 i_reset  input  1  synchronous, active-low reset; sampled on the i_clk rising edge.
REQ-007 i_rx  input  1  asynchronous serial line; idles high.
REQ-008 o_data  output  DBIT  last correctly framed byte, LSB received first.
REQ-009 o_rx_done_tick  output  1  one-cycle strobe; o_data is valid in the same cycle; drives the RX FIFO write enable.
REQ-010 o_frame_err  output  1  one-cycle strobe; stop bit sampled low.
REQ-011 o_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value.
REQ-013 Tick generator: a DVSR_BIT-wide free-running counter SHALL count 0..DVSR-1 and wrap; tick SHALL be high for the single cycle at count DVSR-1.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, with s (4-bit oversample counter) and n (bit index).
REQ-015 IDLE: on synchronized rx = 0, go to START with s = 0; ticks are ignored in IDLE.
REQ-016 START: on each tick increment s; at the tick where s = 7, if rx = 0 go to DATA with s = 0 and n = 0; otherwise (glitch) return to IDLE with no strobe.
REQ-017 DATA: sample rx at the ticks where s = 7, 8 and 9; at the tick where s = 15, shift the 2-of-3 majority into the MSB of the shift register (right shift) and set s = 0.
REQ-018 DATA: after shifting bit n = DBIT-1, go to STOP; otherwise increment n.
REQ-019 STOP: sample rx at the tick where s = SB_TICK/2; at the tick where s = SB_TICK-1, return to IDLE.
REQ-020 On leaving STOP with stop sample = 1: load o_data with the shift register and assert o_rx_done_tick for exactly the next cycle.
REQ-021 On leaving STOP with stop sample = 0: assert o_frame_err for exactly the next cycle; o_data and o_rx_done_tick SHALL remain unchanged.
REQ-022 o_rx_done_tick and o_frame_err SHALL never be asserted together.
REQ-023 A new start edge SHALL be accepted in the first cycle back in IDLE, so back-to-back frames with a single stop bit are received without loss.
REQ-024 The block SHALL not apply back-pressure; FIFO overflow handling belongs to the consumer.
REQ-025 All outputs SHALL be registered, with no combinational path from i_rx to any output.

Reset
REQ-026 While i_reset = 0: state = IDLE; s, n, shift register, tick counter and o_data = 0.
REQ-027 While i_reset = 0: both synchronizer flops = 1, o_rx_done_tick = 0, o_frame_err = 0, o_busy = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame silently, with no strobe on either o_rx_done_tick or o_frame_err.
REQ-029 After reset release, the first start bit SHALL only be accepted once the synchronized line has been seen high.

Structure
REQ-030 FSM state encodings and default parameter values SHALL live in the shared UART package used by the transmitter and debug unit.
REQ-031 The tick generator SHALL be a separate sub-module, baud_tick_gen (params DVSR, DVSR_BIT; output o_tick), shareable with the transmitter.

Verification
REQ-032 Send 0xA5, 8N1, at 16*DVSR clocks per bit -> one o_rx_done_tick with o_data = 0xA5; o_frame_err stays 0.
REQ-033 Send 0x00, then 0xFF back-to-back with one stop bit each -> two strobes, o_data = 0x00 then 0xFF.
REQ-034 Send 0x3C with the stop bit forced low -> o_frame_err pulses once; no o_rx_done_tick; o_data keeps its previous value.
REQ-035 Drive a low pulse of 3*DVSR clocks on an idle line -> FSM returns to IDLE; no strobes; o_busy high for under 8*DVSR clocks.
REQ-036 Send 0x5A with a 1-tick inverted glitch at s = 8 of bit 3 -> majority vote yields o_data = 0x5A.
REQ-037 Assert i_reset = 0 during bit 4 of a frame, release it, then send 0x11 -> no strobe for the aborted frame; then o_data = 0x11.
